fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ptr.sv | 36 +++
 rtl/fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_fifo_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO controller.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 9;
  localparam int unsigned FIFO_DATA_WIDTH = 32;
  localparam int unsigned FIFO_CNT_WIDTH  = FIFO_ADDR_WIDTH + 1;

  // Pointer carries one extra wrap bit beyond the RAM address
  typedef logic [FIFO_CNT_WIDTH-1:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: one extra MSB distinguishes full from empty.
module fifo_ptr #(
  parameter int unsigned PTR_W = fifo_pkg::FIFO_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer: clear wins over increment, wraps naturally
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external RAM with 1-cycle registered read.
// Optional sticky overflow/underflow flags: define FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = FIFO_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  flush,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          rd_vld_q;
  logic          rd_vld_d;

  // Status flags from registered pointers only
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // Accepted transfers; flush blocks both, no fall-through when empty
  assign ram_wr_en   = wr_req & ~full & ~flush;
  assign ram_rd_en   = rd_req & ~empty & ~flush;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  fifo_ptr #(.PTR_W(CW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ram_wr_en),
    .clr_i (flush),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.PTR_W(CW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ram_rd_en),
    .clr_i (flush),
    .ptr_o (rd_ptr)
  );

  // Read data lands one cycle after an accepted read; flush gates ram_rd_en
  always_comb begin
    rd_vld_d = ram_rd_en;
  end

  // Read-valid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_vld_d;
    end
  end

  assign rd_data_valid = rd_vld_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q;
  logic ovf_d;
  logic udf_q;
  logic udf_d;

  // Sticky error flags, cleared only by flush or reset
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_req && full) ovf_d = 1'b1;
      if (rd_req && empty) udf_d = 1'b1;
    end
  end

  // Error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl (ADDR_WIDTH=2).
module tb_fifo_ctrl;

  localparam int unsigned AW = 2;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          wr_req;
  logic          rd_req;
  logic          flush;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic          rd_data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks;
  int failures;

  fifo_ctrl #(
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (3),
    .AEMPTY_THRESH (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_req        (wr_req),
    .rd_req        (rd_req),
    .flush         (flush),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_rd_en     (ram_rd_en),
    .ram_rd_addr   (ram_rd_addr),
    .rd_data_valid (rd_data_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's request at the falling edge, then settle
  task automatic cycle(input logic w, input logic r, input logic f);
    @(negedge clk);
    wr_req = w;
    rd_req = r;
    flush  = f;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n  = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
    #1;
    check_val("rst_empty",   32'(empty), 1);
    check_val("rst_aempty",  32'(almost_empty), 1);
    check_val("rst_full",    32'(full), 0);
    check_val("rst_afull",   32'(almost_full), 0);
    check_val("rst_count",   32'(count), 0);
    check_val("rst_wr_en",   32'(ram_wr_en), 0);
    check_val("rst_rd_en",   32'(ram_rd_en), 0);
    check_val("rst_wr_addr", 32'(ram_wr_addr), 0);
    check_val("rst_rd_addr", 32'(ram_rd_addr), 0);
    check_val("rst_rdv",     32'(rd_data_valid), 0);
    check_val("rst_ovf",     32'(overflow), 0);
    check_val("rst_udf",     32'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with four pushes
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check_val("fill_wr_en",   32'(ram_wr_en), 1);
      check_val("fill_wr_addr", 32'(ram_wr_addr), 32'(i));
      check_val("fill_count",   32'(count), 32'(i));
      check_val("fill_afull",   32'(almost_full), (i >= 3) ? 32'd1 : 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b0);
    check_val("full_flag",  32'(full), 1);
    check_val("full_count", 32'(count), 4);
    check_val("full_afull", 32'(almost_full), 1);
    check_val("full_empty", 32'(empty), 0);

    // Push while full is refused
    cycle(1'b1, 1'b0, 1'b0);
    check_val("ovf_wr_en", 32'(ram_wr_en), 0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("ovf_count", 32'(count), 4);
    check_val("ovf_flag",  32'(overflow), 32'(ERR_ON));

    // Drain four, valid follows each pop by one cycle
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      check_val("drain_rd_en",   32'(ram_rd_en), 1);
      check_val("drain_rd_addr", 32'(ram_rd_addr), 32'(i));
      check_val("drain_rdv",     32'(rd_data_valid), (i > 0) ? 32'd1 : 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b0);
    check_val("drain_last_rdv", 32'(rd_data_valid), 1);
    check_val("drain_empty",    32'(empty), 1);
    check_val("drain_count",    32'(count), 0);
    cycle(1'b0, 1'b1, 1'b0);
    check_val("udf_rd_en", 32'(ram_rd_en), 0);
    check_val("udf_rdv",   32'(rd_data_valid), 0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("udf_flag",     32'(underflow), 32'(ERR_ON));
    check_val("udf_rdv_idle", 32'(rd_data_valid), 0);

    // Push+pop while empty: only the write goes through
    cycle(1'b1, 1'b1, 1'b0);
    check_val("pp_empty_wr_en", 32'(ram_wr_en), 1);
    check_val("pp_empty_rd_en", 32'(ram_rd_en), 0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("pp_empty_count", 32'(count), 1);

    // Six push/pop pairs at count=1 wrap addresses and pointer MSB
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      check_val("wrap_wr_en",   32'(ram_wr_en), 1);
      check_val("wrap_rd_en",   32'(ram_rd_en), 1);
      check_val("wrap_wr_addr", 32'(ram_wr_addr), 32'((i + 1) % 4));
      check_val("wrap_rd_addr", 32'(ram_rd_addr), 32'(i % 4));
      check_val("wrap_count",   32'(count), 1);
      check_val("wrap_full",    32'(full), 0);
      check_val("wrap_empty",   32'(empty), 0);
    end
    cycle(1'b0, 1'b0, 1'b0);
    check_val("wrap_end_count", 32'(count), 1);

    // Refill to four, then push+pop while full: only the read goes through
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("refill_full", 32'(full), 1);
    cycle(1'b1, 1'b1, 1'b0);
    check_val("pp_full_wr_en", 32'(ram_wr_en), 0);
    check_val("pp_full_rd_en", 32'(ram_rd_en), 1);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("pp_full_count", 32'(count), 3);

    // Flush at count=3 with push+pop asserted
    cycle(1'b1, 1'b1, 1'b1);
    check_val("flush_wr_en", 32'(ram_wr_en), 0);
    check_val("flush_rd_en", 32'(ram_rd_en), 0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("flush_count", 32'(count), 0);
    check_val("flush_empty", 32'(empty), 1);
    check_val("flush_ovf",   32'(overflow), 0);
    check_val("flush_udf",   32'(underflow), 0);
    check_val("flush_rdv",   32'(rd_data_valid), 0);

    // Reset during an accepted read abandons the pending valid
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check_val("rstmid_rd_en", 32'(ram_rd_en), 1);
    rst_n = 1'b0;
    #1;
    check_val("rstmid_count", 32'(count), 0);
    check_val("rstmid_rdv",   32'(rd_data_valid), 0);
    @(negedge clk);
    rd_req = 1'b0;
    rst_n  = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    check_val("rstmid_rdv_rel1", 32'(rd_data_valid), 0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("rstmid_rdv_rel2", 32'(rd_data_valid), 0);
    check_val("rstmid_empty",    32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
